painterengine_gpu_infoarb: RTL and testbench

PAINTERENGINE_GPU_INFOARB -- requirements
Module: painterengine_gpu_infoarb

---
 rtl/painterengine_gpu_infoarb_pkg.sv | 21 ++
 rtl/painterengine_gpu_rrpick.sv | 31 +++
 rtl/painterengine_gpu_infoarb.sv | 129 ++++++++++++
 tb/tb_painterengine_gpu_infoarb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_infoarb_pkg.sv
// rtl/painterengine_gpu_infoarb_pkg.sv - shared constants for the gpuinfo arbiter
package painterengine_gpu_infoarb_pkg;

    localparam logic [31:0] UNIT_IDLE       = 32'd0;
    localparam logic [31:0] UNIT_PROCESSING = 32'd1;
    localparam logic [31:0] UNIT_ERROR      = 32'd2;
    localparam logic [31:0] UNIT_DONE       = 32'd3;

    localparam logic [31:0] OP_RESET        = 32'd0;
    localparam logic [31:0] OP_GETVERSION   = 32'd1;
    localparam logic [31:0] OP_GETDEBUG     = 32'd2;

    localparam logic [31:0] TIMEOUT_RETURN  = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_COMPLETE = 3'd3;
    localparam logic [2:0] ST_RECYCLE  = 3'd4;

endpackage

// File: rtl/painterengine_gpu_rrpick.sv
// rtl/painterengine_gpu_rrpick.sv - combinational round-robin pick starting after last_grant
module painterengine_gpu_rrpick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             any
);

    int k;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        k     = 0;
        // Walk the ring once, beginning with the requester after the last winner.
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last_grant) + i) % N_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                index    = IW'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/painterengine_gpu_infoarb.sv
// rtl/painterengine_gpu_infoarb.sv - arbitrates N requesters onto one gpuinfo unit
module painterengine_gpu_infoarb
    import painterengine_gpu_infoarb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_wire_clock,
    input  logic                 i_wire_reset,
    input  logic [N_REQ-1:0]     i_wire_req_valid,
    input  logic [32*N_REQ-1:0]  i_wire_req_opcode,
    output logic [N_REQ-1:0]     o_wire_rsp_valid,
    output logic [31:0]          o_wire_rsp_state,
    output logic [31:0]          o_wire_rsp_return,
    output logic [N_REQ-1:0]     o_wire_grant,
    output logic                 o_wire_busy,
    output logic [31:0]          o_wire_unit_opcode,
    output logic                 o_wire_unit_resetn,
    input  logic [31:0]          i_wire_unit_state,
    input  logic [31:0]          i_wire_unit_return
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q;
    logic [IW-1:0]    last_grant_q;
    logic [N_REQ-1:0] grant_q;
    logic [31:0]      opcode_q;
    logic [31:0]      rsp_state_q;
    logic [31:0]      rsp_return_q;
    logic [7:0]       wait_cnt_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_index;
    logic             pick_any;
    logic [31:0]      pick_opcode;
    logic             unit_finished;

    painterengine_gpu_rrpick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rrpick (
        .req        (i_wire_req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .index      (pick_index),
        .any        (pick_any)
    );

    always_comb begin
        pick_opcode = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_opcode = i_wire_req_opcode[32*k +: 32];
            end
        end
    end

    assign unit_finished = (i_wire_unit_state == UNIT_ERROR) || (i_wire_unit_state == UNIT_DONE);

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(N_REQ - 1);
            grant_q      <= '0;
            opcode_q     <= '0;
            rsp_state_q  <= '0;
            rsp_return_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q      <= pick_grant;
                        last_grant_q <= pick_index;
                        opcode_q     <= pick_opcode;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= '0;
                    // A reset opcode never reaches the unit; it is answered as an error.
                    if (opcode_q == OP_RESET) begin
                        rsp_state_q  <= UNIT_ERROR;
                        rsp_return_q <= '0;
                        state_q      <= ST_COMPLETE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion from the unit takes priority over the timeout on the same edge.
                    if (unit_finished) begin
                        rsp_state_q  <= i_wire_unit_state;
                        rsp_return_q <= i_wire_unit_return;
                        state_q      <= ST_COMPLETE;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        rsp_state_q  <= UNIT_ERROR;
                        rsp_return_q <= TIMEOUT_RETURN;
                        state_q      <= ST_COMPLETE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ST_COMPLETE: begin
                    grant_q <= '0;
                    state_q <= ST_RECYCLE;
                end
                ST_RECYCLE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wire_rsp_valid   = (state_q == ST_COMPLETE) ? grant_q : '0;
    assign o_wire_rsp_state   = rsp_state_q;
    assign o_wire_rsp_return  = rsp_return_q;
    assign o_wire_grant       = grant_q;
    assign o_wire_busy        = (state_q != ST_IDLE);
    assign o_wire_unit_opcode = (state_q == ST_ISSUE) ? opcode_q : '0;
    assign o_wire_unit_resetn = ~i_wire_reset & (state_q != ST_RECYCLE);

endmodule

// File: tb/tb_painterengine_gpu_infoarb.sv
// tb/tb_painterengine_gpu_infoarb.sv - scoreboard bench for the gpuinfo arbiter
module tb_painterengine_gpu_infoarb;
    import painterengine_gpu_infoarb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_opcode;
    logic [N-1:0]     rsp_valid;
    logic [31:0]      rsp_state;
    logic [31:0]      rsp_return;
    logic [N-1:0]     grant;
    logic             busy;
    logic [31:0]      unit_opcode;
    logic             unit_resetn;
    logic [31:0]      unit_state;
    logic [31:0]      unit_return;

    painterengine_gpu_infoarb #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_wire_clock       (clk),
        .i_wire_reset       (rst),
        .i_wire_req_valid   (req_valid),
        .i_wire_req_opcode  (req_opcode),
        .o_wire_rsp_valid   (rsp_valid),
        .o_wire_rsp_state   (rsp_state),
        .o_wire_rsp_return  (rsp_return),
        .o_wire_grant       (grant),
        .o_wire_busy        (busy),
        .o_wire_unit_opcode (unit_opcode),
        .o_wire_unit_resetn (unit_resetn),
        .i_wire_unit_state  (unit_state),
        .i_wire_unit_return (unit_return)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // gpuinfo unit: answers u_delay cycles after it samples a non-zero opcode.
    int          u_delay = 0;
    int          u_cnt;
    logic [31:0] u_op;

    function automatic logic [31:0] unit_res_state(input logic [31:0] op);
        return (op == 32'd1 || op == 32'd2) ? 32'd3 : 32'd2;
    endfunction

    function automatic logic [31:0] unit_res_ret(input logic [31:0] op);
        if (op == 32'd1) return 32'h0000_0001;
        if (op == 32'd2) return 32'h2024_0612;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (!unit_resetn) begin
            unit_state  <= 32'd0;
            unit_return <= 32'd0;
            u_cnt       <= 0;
            u_op        <= 32'd0;
        end else if (unit_opcode != 32'd0) begin
            if (u_delay == 0) begin
                unit_state  <= unit_res_state(unit_opcode);
                unit_return <= unit_res_ret(unit_opcode);
            end else begin
                unit_state <= 32'd1;
                u_cnt      <= u_delay;
                u_op       <= unit_opcode;
            end
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) begin
                unit_state  <= unit_res_state(u_op);
                unit_return <= unit_res_ret(u_op);
            end
        end
    end

    // Reference: what a requester should receive for a given opcode and unit delay.
    function automatic logic [31:0] exp_state(input logic [31:0] op, input int dly);
        if (op == 32'd0) return 32'd2;
        if (dly >= TO) return 32'd2;
        return (op == 32'd1 || op == 32'd2) ? 32'd3 : 32'd2;
    endfunction

    function automatic logic [31:0] exp_ret(input logic [31:0] op, input int dly);
        if (op == 32'd0) return 32'd0;
        if (dly >= TO) return 32'hFFFF_FFFF;
        if (op == 32'd1) return 32'h0000_0001;
        if (op == 32'd2) return 32'h2024_0612;
        return 32'd0;
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] st;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          m_last = N - 1;
    logic [N-1:0] iss_mask = '0;
    logic [31:0] iss_ops [N];
    int          iss_id = 0;
    bit          chaos = 1'b0;

    // Requester side: loads new batches, drops valid after its response, optionally misbehaves.
    initial begin
        int seen_id;
        seen_id    = 0;
        req_valid  = '0;
        req_opcode = '0;
        forever begin
            @(negedge clk);
            if (iss_id != seen_id) begin
                seen_id   = iss_id;
                req_valid = iss_mask;
                for (int k = 0; k < N; k++) req_opcode[32*k +: 32] = iss_ops[k];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (rsp_valid[k]) begin
                        req_valid[k] = 1'b0;
                    end else if (chaos && grant[k]) begin
                        case ($urandom_range(0, 3))
                            0: begin
                                req_valid[k] = 1'b0;
                                req_opcode[32*k +: 32] = $urandom;
                            end
                            1: req_opcode[32*k +: 32] = $urandom;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Monitor: every response pulse is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: rsp_valid %b with nothing expected", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                    check("rsp_state", rsp_state, e.st);
                    check("rsp_return", rsp_return, e.ret);
                end
            end
        end
    end

    task automatic issue_batch(input logic [N-1:0] mask, input bit expect_rsp);
        exp_t e;
        int   last_k;
        iss_mask = mask;
        iss_id++;
        last_k = m_last;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_last + i) % N;
            if (mask[k]) begin
                e.idx = k;
                e.st  = exp_state(iss_ops[k], u_delay);
                e.ret = exp_ret(iss_ops[k], u_delay);
                if (expect_rsp) exp_q.push_back(e);
                last_k = k;
            end
        end
        m_last = last_k;
    endtask

    task automatic wait_rsp(input int k, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid[k] && n < limit);
        if (!rsp_valid[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_wait_%0d: no response after %0d cycles", k, n);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while ((busy || req_valid != '0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || req_valid != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: busy %b valid %b after %0d cycles", busy, req_valid, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        iss_mask = '0;
        iss_id++;
        m_last = N - 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_state"}, rsp_state, 32'd0);
        check({tag, "_rsp_return"}, rsp_return, 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_unit_opcode"}, unit_opcode, 32'd0);
        check({tag, "_unit_resetn"}, 32'(unit_resetn), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit nz;
        logic [N-1:0] mask;
        for (int k = 0; k < N; k++) iss_ops[k] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single GETVERSION from requester 1, then the recycle pulse.
        @(posedge clk);
        #1;
        iss_ops[1] = OP_GETVERSION;
        issue_batch(4'b0010, 1'b1);
        wait_rsp(1, 20, n);
        check("lat_single", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        check("recycle_resetn_low", 32'(unit_resetn), 32'd0);
        check("recycle_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        check("recycle_resetn_high", 32'(unit_resetn), 32'd1);
        wait_idle(20);

        // Three GETDEBUG requests after reset: order 0, 2, 3 with 5-cycle spacing.
        do_reset();
        iss_ops[0] = OP_GETDEBUG;
        iss_ops[2] = OP_GETDEBUG;
        iss_ops[3] = OP_GETDEBUG;
        issue_batch(4'b1101, 1'b1);
        wait_rsp(0, 20, n);
        check("lat_first_after_reset", 32'(n), 32'd3);
        wait_rsp(2, 20, n);
        check("spacing_0_2", 32'(n), 32'd5);
        wait_rsp(3, 20, n);
        check("spacing_2_3", 32'(n), 32'd5);
        wait_idle(20);

        // Unknown opcode, then opcode 0 which must never reach the unit.
        iss_ops[1] = 32'd7;
        issue_batch(4'b0010, 1'b1);
        wait_idle(40);
        iss_ops[2] = OP_RESET;
        issue_batch(4'b0100, 1'b1);
        n  = 0;
        nz = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (unit_opcode != 32'd0) nz = 1'b1;
        end while (!rsp_valid[2] && n < 20);
        check("op0_unit_opcode_quiet", 32'(nz), 32'd0);
        check("op0_latency", 32'(n), 32'd2);
        wait_idle(20);

        // Unit that never finishes: timeout after TO wait cycles.
        u_delay = 1000;
        iss_ops[3] = OP_GETVERSION;
        issue_batch(4'b1000, 1'b1);
        wait_rsp(3, 60, n);
        check("lat_timeout", 32'(n), 32'(TO + 2));
        @(posedge clk);
        #1;
        check("timeout_recycle_resetn", 32'(unit_resetn), 32'd0);
        wait_idle(20);

        // Unit finishes on the very edge the limit is reached: completion wins.
        u_delay = TO - 1;
        iss_ops[0] = OP_GETVERSION;
        issue_batch(4'b0001, 1'b1);
        wait_rsp(0, 60, n);
        check("lat_limit_edge", 32'(n), 32'(TO + 2));
        wait_idle(20);

        // Reset while waiting on the unit: immediate reset outputs, no response.
        u_delay = 6;
        iss_ops[0] = OP_GETDEBUG;
        issue_batch(4'b0001, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        iss_mask = '0;
        iss_id++;
        m_last = N - 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        u_delay = 0;
        iss_ops[2] = OP_GETDEBUG;
        issue_batch(4'b0100, 1'b1);
        wait_rsp(2, 20, n);
        check("lat_after_midreset", 32'(n), 32'd3);
        wait_idle(20);

        // Randomised batches with misbehaving requesters.
        chaos = 1'b1;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                3: u_delay = $urandom_range(1, TO - 1);
                4: u_delay = TO - 1;
                5: u_delay = TO;
                default: u_delay = 0;
            endcase
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 4))
                    0: iss_ops[k] = 32'd0;
                    1: iss_ops[k] = 32'd1;
                    2: iss_ops[k] = 32'd2;
                    3: iss_ops[k] = 32'd7;
                    default: iss_ops[k] = $urandom;
                endcase
            end
            @(posedge clk);
            #1;
            issue_batch(mask, 1'b1);
            wait_idle(200);
        end
        chaos = 1'b0;

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
